// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with valid-ready handshake.
// Extension happens combinationally at the input and the result is registered
// into stage 0. It then moves through STAGES elastic register stages.
// Optional macro EXT_PIPE_COUNT_EN adds a 32-bit output-transfer counter (xfer_cnt).
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_mode,
    input  logic [IMM_W-1:0]            in_imm,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [$clog2(DATA_W/8)-1:0] in_off,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_err
`ifdef EXT_PIPE_COUNT_EN
    ,
    output logic [31:0]                 xfer_cnt
`endif
);

    typedef enum logic [2:0] {
        MODE_ZEXT  = 3'b000,
        MODE_SEXT  = 3'b001,
        MODE_UPPER = 3'b010,
        MODE_LB    = 3'b011,
        MODE_LBU   = 3'b100,
        MODE_LH    = 3'b101,
        MODE_LHU   = 3'b110,
        MODE_PASS  = 3'b111
    } mode_e;

    logic [DATA_W-1:0]              shifted;
    logic [7:0]                     lane_b;
    logic [15:0]                    lane_h;
    logic [DATA_W-1:0]              ext_data;
    logic                           ext_err;

    logic [STAGES-1:0]              vld_q, vld_d;
    logic [STAGES-1:0][DATA_W-1:0]  data_q, data_d;
    logic [STAGES-1:0]              err_q, err_d;
    logic [STAGES-1:0]              load;
    logic                           full_tail;

    // Input-side extension: lane select by byte offset (little-endian), then extend.
    always_comb begin
        shifted  = in_data >> {in_off, 3'b000};
        lane_b   = shifted[7:0];
        lane_h   = shifted[15:0];
        ext_data = '0;
        ext_err  = 1'b0;
        case (mode_e'(in_mode))
            MODE_ZEXT:  ext_data = DATA_W'(in_imm);
            MODE_SEXT:  ext_data = DATA_W'($signed(in_imm));
            MODE_UPPER: ext_data = DATA_W'(in_imm) << (DATA_W - IMM_W);
            MODE_LB:    ext_data = DATA_W'($signed(lane_b));
            MODE_LBU:   ext_data = DATA_W'(lane_b);
            MODE_LH: begin
                if (in_off[0]) ext_err  = 1'b1;
                else           ext_data = DATA_W'($signed(lane_h));
            end
            MODE_LHU: begin
                if (in_off[0]) ext_err  = 1'b1;
                else           ext_data = DATA_W'(lane_h);
            end
            MODE_PASS:  ext_data = in_data;
            default:    ext_data = '0;
        endcase
    end

    // Stage load enables: the backward ready chain load[i] = !vld[i] | load[i+1]
    // is flattened to out_ready | (some stage from i to the end is empty).
    always_comb begin
        full_tail = 1'b1;
        load      = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            full_tail             = full_tail & vld_q[STAGES-1-j];
            load[STAGES-1-j]      = out_ready | ~full_tail;
        end
        in_ready = load[0];
    end

    // Next-state for stage registers. Data is updated only when a valid item
    // arrives, so the output stage retains its last value while empty.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        err_d  = err_q;
        if (load[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = ext_data;
                err_d[0]  = ext_err;
            end
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                    err_d[i]  = err_q[i-1];
                end
            end
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];

`ifdef EXT_PIPE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Output transfer counter; wraps naturally at 32 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (IMM_W=16, DATA_W=32, STAGES=2).
// Expected results are queued at input acceptance and popped at output transfer.
// Counter checks are compiled only when EXT_PIPE_COUNT_EN is defined.
module tb_ext_pipe;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STAGES = 2;

    typedef struct packed {
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [31:0] data;
        logic [1:0]  off;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_off;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
`ifdef EXT_PIPE_COUNT_EN
    logic [31:0] xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_data   (in_data),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef EXT_PIPE_COUNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: returns {err, data}.
    function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] imm,
                                          input logic [31:0] d, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (m)
            3'd0: return {1'b0, 16'h0000, imm};
            3'd1: return {1'b0, {16{imm[15]}}, imm};
            3'd2: return {1'b0, imm, 16'h0000};
            3'd3: return {1'b0, {24{b[7]}}, b};
            3'd4: return {1'b0, 24'h000000, b};
            3'd5: return off[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
            3'd6: return off[0] ? {1'b1, 32'h0} : {1'b0, 16'h0000, h};
            default: return {1'b0, d};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_imm = '0; in_data = '0; in_off = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 00000000", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
`ifdef EXT_PIPE_COUNT_EN
        checks++; if (xfer_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h expected 0", xfer_cnt); end
`endif
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int n;
        logic [32:0] e;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 3'b001; in_imm = 16'h8001; in_data = '0; in_off = '0;
        #4;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b expected 1", in_ready); end
        if (in_valid && in_ready) exp_q.push_back({1'b0, 32'hFFFF8001});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL latency got %0d expected 2", n); end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL lat_queue got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({out_err, out_data} !== e) begin
                errors++; $display("FAIL lat_result got err=%b data=%h expected err=%b data=%h", out_err, out_data, e[32], e[31:0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        vec_t v[$];
        int sent = 0, got = 0, cyc = 0;
        logic [32:0] e;
        v.push_back('{3'b010, 16'h1234, 32'h0,        2'd0, 1'b0, 32'h12340000});
        v.push_back('{3'b000, 16'hFFFF, 32'h0,        2'd0, 1'b0, 32'h0000FFFF});
        v.push_back('{3'b001, 16'h1234, 32'h0,        2'd0, 1'b0, 32'h00001234});
        v.push_back('{3'b011, 16'h0,    32'h80FF7F01, 2'd3, 1'b0, 32'hFFFFFF80});
        v.push_back('{3'b100, 16'h0,    32'h80FF7F01, 2'd3, 1'b0, 32'h00000080});
        v.push_back('{3'b011, 16'h0,    32'h80FF7F01, 2'd1, 1'b0, 32'h0000007F});
        v.push_back('{3'b100, 16'h0,    32'h80FF7F01, 2'd0, 1'b0, 32'h00000001});
        v.push_back('{3'b101, 16'h0,    32'h80FF7F01, 2'd2, 1'b0, 32'hFFFF80FF});
        v.push_back('{3'b101, 16'h0,    32'h80FF7F01, 2'd0, 1'b0, 32'h00007F01});
        v.push_back('{3'b110, 16'h0,    32'h80FF7F01, 2'd2, 1'b0, 32'h000080FF});
        v.push_back('{3'b110, 16'h0,    32'h80FF7F01, 2'd1, 1'b1, 32'h00000000});
        v.push_back('{3'b101, 16'h0,    32'h80FF7F01, 2'd3, 1'b1, 32'h00000000});
        v.push_back('{3'b111, 16'hABCD, 32'h80FF7F01, 2'd2, 1'b0, 32'h80FF7F01});
        out_ready = 1'b1;
        while (got < v.size() && cyc < 100) begin
            if (sent < v.size()) begin
                in_valid = 1'b1; in_mode = v[sent].mode; in_imm = v[sent].imm;
                in_data = v[sent].data; in_off = v[sent].off;
            end else begin
                in_valid = 1'b0;
            end
            #4;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL modes_extra got data=%h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_data} !== e) begin
                        errors++; $display("FAIL modes[%0d] got err=%b data=%h expected err=%b data=%h", got, out_err, out_data, e[32], e[31:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({v[sent].err, v[sent].exp});
                sent++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != v.size()) begin errors++; $display("FAIL modes_count got %0d expected %0d", got, v.size()); end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        vec_t t;
        int sent = 0, got = 0, cyc = 0;
        logic [32:0] e;
        logic [32:0] held;
        logic have_held = 1'b0;
        logic seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            t.mode = 3'($urandom_range(0, 7));
            t.imm  = 16'($urandom);
            t.data = $urandom;
            t.off  = 2'($urandom_range(0, 3));
            {t.err, t.exp} = model(t.mode, t.imm, t.data, t.off);
            v.push_back(t);
        end
        while (got < 6 && cyc < 100) begin
            out_ready = (cyc >= 4);
            if (sent < 6) begin
                in_valid = 1'b1; in_mode = v[sent].mode; in_imm = v[sent].imm;
                in_data = v[sent].data; in_off = v[sent].off;
            end else begin
                in_valid = 1'b0;
            end
            #4;
            if (cyc == 3) begin
                checks++;
                if (in_ready !== 1'b0 || sent != STAGES) begin
                    errors++; $display("FAIL b2b_fill got in_ready=%b accepted=%0d expected in_ready=0 accepted=%0d", in_ready, sent, STAGES);
                end
            end
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    checks++;
                    if ({out_err, out_data} !== held) begin
                        errors++; $display("FAIL b2b_stall_hold got %h expected %h", {out_err, out_data}, held);
                    end
                end
                held = {out_err, out_data};
                have_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got data=%h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_data} !== e) begin
                        errors++; $display("FAIL b2b[%0d] got err=%b data=%h expected err=%b data=%h", got, out_err, out_data, e[32], e[31:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({v[sent].err, v[sent].exp});
                sent++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count got %0d expected 6", got); end
        for (int i = 0; i < 4; i++) begin
            #4; if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen || exp_q.size() != 0) begin errors++; $display("FAIL b2b_dup got extra_valid=%b pending=%0d expected 0 0", seen, exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        logic seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mode = 3'b111; in_imm = '0; in_data = 32'hC0DE0000 + i; in_off = '0;
            #4;
            if (in_valid && in_ready) exp_q.push_back({1'b0, in_data});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got out_valid=%b expected 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h expected 00000000", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b expected 0", out_err); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #4; if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_stale got out_valid=1 expected 0"); end
    endtask

`ifdef EXT_PIPE_COUNT_EN
    task automatic test_counter();
        int sent, got, cyc;
        rst = 1'b1; #1; rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0;
        while (got < 5 && cyc < 100) begin
            in_valid = (sent < 5); in_mode = 3'b000; in_imm = 16'(sent + 1); in_data = '0; in_off = '0;
            #4;
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        checks++; if (xfer_cnt !== 32'd5) begin errors++; $display("FAIL cnt_five got %0d expected 5", xfer_cnt); end
        force dut.cnt_q = 32'hFFFFFFFF;
        #1 release dut.cnt_q;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            #3;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
            @(posedge clk); #1;
            checks++;
            if (xfer_cnt !== 32'(k)) begin errors++; $display("FAIL cnt_wrap[%0d] got %h expected %h", k, xfer_cnt, 32'(k)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_modes();
        test_back_to_back();
        test_reset_midstream();
`ifdef EXT_PIPE_COUNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Performs immediate extension (zero, sign, upper-load) and load-data lane extraction with extension (byte/half, signed/unsigned).
- Elastic valid/ready pipeline with backpressure. Sits between the decode/memory stages and the ALU/writeback mux.

Parameters:
- IMM_W, 16, immediate field width; must satisfy IMM_W <= DATA_W.
- DATA_W, 32, datapath/output width; multiple of 16, at least 32.
- STAGES, 2, register stages between input and output; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_mode  in  3  operation select (see Behaviour).
- in_imm  in  IMM_W  immediate field.
- in_data  in  DATA_W  loaded memory word.
- in_off  in  log2(DATA_W/8)  byte offset within in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  extended result.
- out_err  out  1  misaligned halfword access flag, qualified by out_valid.

Behaviour:
- Reset (async, immediate): all stage valid bits 0, out_valid=0, out_data=0, out_err=0. Any in-flight transactions are discarded; no output is produced for them after reset deasserts.
- Modes (computed combinationally at input, registered into stage 0):
  - 000: zero-extend in_imm.
  - 001: sign-extend in_imm from bit IMM_W-1.
  - 010: upper, {in_imm, DATA_W-IMM_W zeros}.
  - 011: byte at in_off, sign-extended.
  - 100: byte at in_off, zero-extended.
  - 101: half at in_off, sign-extended.
  - 110: half at in_off, zero-extended.
  - 111: pass in_data unchanged.
- Lane numbering is little-endian: byte k = in_data[8k+7:8k]; the half uses the two bytes starting at in_off.
- Half modes with in_off[0]=1: result 0, err=1. All other modes: err=0. in_off is ignored in modes 000, 001, 010, 111.
- Pipeline: STAGES registers, each with its own valid bit. Stage i loads when !valid[i] or stage i+1 is taking its contents; the last stage advances on out_ready.
- in_ready = !valid[0] or stage 0 advancing this cycle, so a full pipe with out_ready=1 sustains 1 transaction/cycle.
- Handshake: a transfer occurs when valid && ready at a rising edge. Latency from input transfer to out_valid is exactly STAGES cycles with no stall.
- While out_valid=1 and out_ready=0, out_data and out_err hold stable. Upstream stages fill, and in_ready drops once all stages are valid.
- Ordering: strictly in order, with no drops or duplicates.
- Simultaneous input accept and output drain in the same cycle is legal and keeps occupancy unchanged.
- A stage's data is don't-care while its valid=0, except out_data/out_err, which retain their last value (reset value 0).

Optional Feature:
- Macro EXT_PIPE_COUNT_EN.
- Defined: adds output port xfer_cnt (32 bits) counting output transfers (out_valid && out_ready). It is reset to 0 by rst and wraps from 0xFFFFFFFF to 0.
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Mode 001, in_imm=16'h8001, STAGES=2, out_ready=1 -> out_valid exactly 2 cycles later, out_data=32'hFFFF8001, out_err=0.
- Mode 010, in_imm=16'h1234 -> 32'h12340000. Mode 000, in_imm=16'hFFFF -> 32'h0000FFFF.
- in_data=32'h80FF7F01, modes 011/100 at in_off=3 -> 32'hFFFFFF80 / 32'h00000080. Mode 101 at in_off=2 -> 32'hFFFF80FF. Mode 110 at in_off=1 -> data 0, err=1.
- Stream 6 back-to-back transactions with out_ready held 0 for 4 cycles -> in_ready falls after STAGES accepts, out_data stable during the stall, all 6 results emerge in order with no loss or duplicates.
- Assert rst mid-stream with 2 transactions in flight -> out_valid=0 immediately (async), outputs 0, no stale result emerges after release.
- With EXT_PIPE_COUNT_EN, 5 completed transfers -> xfer_cnt=5. Preload the counter to near 0xFFFFFFFF via force, then perform 2 transfers -> wraps to 0x00000000 after the first.
